// File: rtl/if_id_ex_pipe.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX) with stall/flush/redirect
// handling and saturating hazard-event counters.
module if_id_ex_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall_F,
  input  logic             Stall_D,
  input  logic             Flush_D,
  input  logic             Flush_E,
  input  logic             PCSrc_E,
  input  logic [31:0]      PCTarget_E,
  input  logic [31:0]      Instr_F,
  output logic [31:0]      PC_F,
  output logic [31:0]      Instr_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PCPlus4_D,
  output logic             Valid_D,
  input  logic [31:0]      RD1_D,
  input  logic [31:0]      RD2_D,
  input  logic [31:0]      Imm_D,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_D,
  input  logic [9:0]       Ctrl_D,
  output logic [31:0]      RD1_E,
  output logic [31:0]      RD2_E,
  output logic [31:0]      Imm_E,
  output logic [31:0]      PC_E,
  output logic [31:0]      PCPlus4_E,
  output logic [4:0]       RS1_E,
  output logic [4:0]       RS2_E,
  output logic [4:0]       RD_E,
  output logic [9:0]       Ctrl_E,
  output logic             Valid_E,
  input  logic             CntClr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] RedirCnt
);

  logic [31:0] pc_plus4_f;
  assign pc_plus4_f = PC_F + 32'd4;

  // Redirect outranks a fetch stall so a taken branch is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_F <= RESET_PC;
    end else if (PCSrc_E) begin
      PC_F <= PCTarget_E;
    end else if (!Stall_F) begin
      PC_F <= pc_plus4_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (Flush_D) begin
      Instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (!Stall_D) begin
      Instr_D   <= Instr_F;
      PC_D      <= PC_F;
      PCPlus4_D <= pc_plus4_f;
      Valid_D   <= 1'b1;
    end
  end

  // A flushed EX slot carries all-zero control, so it cannot write state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD1_E     <= '0;
      RD2_E     <= '0;
      Imm_E     <= '0;
      PC_E      <= '0;
      PCPlus4_E <= '0;
      RS1_E     <= '0;
      RS2_E     <= '0;
      RD_E      <= '0;
      Ctrl_E    <= '0;
      Valid_E   <= 1'b0;
    end else if (Flush_E) begin
      RD1_E     <= '0;
      RD2_E     <= '0;
      Imm_E     <= '0;
      PC_E      <= '0;
      PCPlus4_E <= '0;
      RS1_E     <= '0;
      RS2_E     <= '0;
      RD_E      <= '0;
      Ctrl_E    <= '0;
      Valid_E   <= 1'b0;
    end else begin
      RD1_E     <= RD1_D;
      RD2_E     <= RD2_D;
      Imm_E     <= Imm_D;
      PC_E      <= PC_D;
      PCPlus4_E <= PCPlus4_D;
      RS1_E     <= RS1_D;
      RS2_E     <= RS2_D;
      RD_E      <= RD_D;
      Ctrl_E    <= Ctrl_D;
      Valid_E   <= Valid_D;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != {CNT_W{1'b1}}))
      return cnt + 1'b1;
    return cnt;
  endfunction

  // Clear has priority over any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
      RedirCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
      RedirCnt <= '0;
    end else begin
      StallCnt <= sat_inc(StallCnt, Stall_F);
      FlushCnt <= sat_inc(FlushCnt, Flush_E);
      RedirCnt <= sat_inc(RedirCnt, PCSrc_E);
    end
  end

endmodule

// File: tb/tb_if_id_ex_pipe.sv
// Directed bench for if_id_ex_pipe: sequential fetch, load-use, redirect,
// priority, counter saturation/clear and asynchronous reset.
module tb_if_id_ex_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_F, Stall_D, Flush_D, Flush_E, PCSrc_E, CntClr;
  logic [31:0] PCTarget_E, Instr_F;
  logic [31:0] PC_F, Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D, Valid_E;
  logic [31:0] RD1_D, RD2_D, Imm_D;
  logic [4:0]  RS1_D, RS2_D, RD_D;
  logic [9:0]  Ctrl_D;
  logic [31:0] RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E;
  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic [9:0]  Ctrl_E;
  logic [3:0]  StallCnt, FlushCnt, RedirCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: word tagged with its own address.
  assign Instr_F = PC_F ^ 32'hA5A5_0000;

  if_id_ex_pipe #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E), .Instr_F(Instr_F),
    .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_D(Imm_D),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D), .Ctrl_D(Ctrl_D),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_E(Imm_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .Ctrl_E(Ctrl_E), .Valid_E(Valid_E),
    .CntClr(CntClr), .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RedirCnt(RedirCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hz(input logic sf, input logic sd, input logic fd, input logic fe,
                    input logic ps, input logic [31:0] tgt, input logic clr);
    Stall_F = sf; Stall_D = sd; Flush_D = fd; Flush_E = fe;
    PCSrc_E = ps; PCTarget_E = tgt; CntClr = clr;
  endtask

  initial begin
    rst = 1'b1;
    hz(0, 0, 0, 0, 0, 32'h0, 0);
    RD1_D = 32'h1111_1111; RD2_D = 32'h2222_2222; Imm_D = 32'h0000_0FFC;
    RS1_D = 5'd3; RS2_D = 5'd7; RD_D = 5'd31; Ctrl_D = 10'h2A5;

    #3;
    chk("rst_pc_f",    PC_F, 32'h100);
    chk("rst_instr_d", Instr_D, 32'h13);
    chk("rst_valid_d", {31'd0, Valid_D}, 32'd0);
    chk("rst_valid_e", {31'd0, Valid_E}, 32'd0);
    chk("rst_ctrl_e",  {22'd0, Ctrl_E}, 32'd0);
    chk("rst_stallcnt", {28'd0, StallCnt}, 32'd0);
    #9 rst = 1'b0;

    // Sequential fetch from RESET_PC
    step();
    chk("seq1_pc_f",    PC_F, 32'h104);
    chk("seq1_instr_d", Instr_D, 32'hA5A5_0100);
    chk("seq1_pc_d",    PC_D, 32'h100);
    chk("seq1_pc4_d",   PCPlus4_D, 32'h104);
    chk("seq1_valid_d", {31'd0, Valid_D}, 32'd1);
    chk("seq1_valid_e", {31'd0, Valid_E}, 32'd0);
    step();
    chk("seq2_pc_f",    PC_F, 32'h108);
    chk("seq2_instr_d", Instr_D, 32'hA5A5_0104);
    chk("seq2_valid_e", {31'd0, Valid_E}, 32'd1);
    chk("seq2_pc_e",    PC_E, 32'h100);
    chk("seq2_pc4_e",   PCPlus4_E, 32'h104);
    chk("seq2_ctrl_e",  {22'd0, Ctrl_E}, 32'h2A5);

    // Redirect to 0x1C with both flushes
    hz(0, 0, 1, 1, 1, 32'h1C, 0);
    step();
    chk("rd1_pc_f",    PC_F, 32'h1C);
    chk("rd1_instr_d", Instr_D, 32'h13);
    chk("rd1_valid_d", {31'd0, Valid_D}, 32'd0);
    chk("rd1_ctrl_e",  {22'd0, Ctrl_E}, 32'd0);
    chk("rd1_valid_e", {31'd0, Valid_E}, 32'd0);
    chk("rd1_redir",   {28'd0, RedirCnt}, 32'd1);
    chk("rd1_flush",   {28'd0, FlushCnt}, 32'd1);

    hz(0, 0, 0, 0, 0, 32'h0, 1);
    step();
    chk("clr_pc_f",  PC_F, 32'h20);
    chk("clr_redir", {28'd0, RedirCnt}, 32'd0);
    chk("clr_flush", {28'd0, FlushCnt}, 32'd0);

    // Load-use at PC_F=0x20
    hz(1, 1, 0, 1, 0, 32'h0, 0);
    step();
    chk("lu_pc_f",    PC_F, 32'h20);
    chk("lu_instr_d", Instr_D, 32'hA5A5_001C);
    chk("lu_pc_d",    PC_D, 32'h1C);
    chk("lu_ctrl_e",  {22'd0, Ctrl_E}, 32'd0);
    chk("lu_valid_e", {31'd0, Valid_E}, 32'd0);
    chk("lu_rd1_e",   RD1_E, 32'd0);
    chk("lu_stall",   {28'd0, StallCnt}, 32'd1);
    chk("lu_flush",   {28'd0, FlushCnt}, 32'd1);
    hz(0, 0, 0, 0, 0, 32'h0, 0);
    step();
    chk("lu2_pc_f",    PC_F, 32'h24);
    chk("lu2_instr_d", Instr_D, 32'hA5A5_0020);
    chk("lu2_valid_e", {31'd0, Valid_E}, 32'd1);
    chk("lu2_pc_e",    PC_E, 32'h1C);
    chk("lu2_rd2_e",   RD2_E, 32'h2222_2222);
    chk("lu2_imm_e",   Imm_E, 32'h0000_0FFC);
    chk("lu2_rd_e",    {27'd0, RD_E}, 32'd31);

    // Taken branch with stalls also raised: redirect and flush must win
    hz(1, 1, 1, 1, 1, 32'h400, 0);
    step();
    chk("br_pc_f",    PC_F, 32'h400);
    chk("br_instr_d", Instr_D, 32'h13);
    chk("br_valid_d", {31'd0, Valid_D}, 32'd0);
    chk("br_ctrl_e",  {22'd0, Ctrl_E}, 32'd0);
    chk("br_redir",   {28'd0, RedirCnt}, 32'd1);
    chk("br_stall",   {28'd0, StallCnt}, 32'd2);
    hz(0, 0, 0, 0, 0, 32'h0, 0);
    step();
    chk("br2_pc_f",    PC_F, 32'h404);
    chk("br2_instr_d", Instr_D, 32'hA5A5_0400);

    // Counter saturation at 15 and clear overriding increment
    hz(0, 0, 0, 0, 0, 32'h0, 1);
    step();
    chk("sat_clr", {28'd0, StallCnt}, 32'd0);
    hz(1, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", {28'd0, StallCnt}, 32'd14);
    for (int i = 0; i < 6; i++) step();
    chk("sat_20",   {28'd0, StallCnt}, 32'd15);
    chk("sat_pc_f", PC_F, 32'h408);
    hz(1, 0, 0, 0, 0, 32'h0, 1);
    step();
    chk("clr_wins", {28'd0, StallCnt}, 32'd0);

    // Fill the pipeline, then reset asynchronously between edges
    hz(0, 0, 0, 0, 1, 32'h800, 0);
    step();
    hz(0, 0, 0, 0, 0, 32'h0, 0);
    step();
    step();
    chk("pre_valid_e", {31'd0, Valid_E}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_pc_f",    PC_F, 32'h100);
    chk("ar_instr_d", Instr_D, 32'h13);
    chk("ar_pc_d",    PC_D, 32'd0);
    chk("ar_valid_d", {31'd0, Valid_D}, 32'd0);
    chk("ar_valid_e", {31'd0, Valid_E}, 32'd0);
    chk("ar_ctrl_e",  {22'd0, Ctrl_E}, 32'd0);
    chk("ar_rd1_e",   RD1_E, 32'd0);
    chk("ar_redir",   {28'd0, RedirCnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
